// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the mux scan sequencer.
// Holds the FSM encoding and the channel/select widths.
package mux_scan_ctrl_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Control/datapath bundle of the mux scan sequencer.
// master: control + mux side; slave: the sequencer.
interface mux_scan_ctrl_if
  import mux_scan_ctrl_pkg::*;
();

  logic             start;
  logic             mode;
  logic [SEL_W-1:0] chan;
  logic             mux_f;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic [NUM_CH-1:0] word;
  logic             valid;

  modport master (
    output start, mode, chan, mux_f,
    input  sel, busy, word, valid
  );

  modport slave (
    input  start, mode, chan, mux_f,
    output sel, busy, word, valid
  );

endinterface

// File: rtl/mux_scan_ctrl_settle_cnt.sv
// Per-channel settle counter: clear has priority over enable.
// Ports: clk, rst, clr_i, en_i in; term_o = (count == SETTLE).
module settle_cnt
  import mux_scan_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == CNT_W'(SETTLE));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Drives sel of a 4:1 mux and captures F into word.
// Ports: clk, rst; bus (slave): start/mode/chan/mux_f in, sel/busy/word/valid out.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int unsigned       SETTLE     = 0,
  parameter logic [NUM_CH-1:0] RESET_WORD = '0
) (
  input logic            clk,
  input logic            rst,
  mux_scan_ctrl_if.slave bus
);

  state_e            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic              busy_q;
  logic              valid_q;
  logic              mode_q;
  logic [NUM_CH-1:0] word_q;

  logic accept;
  logic in_scan;
  logic term;
  logic cnt_clr;

  assign in_scan = (state_q == SCAN);
  assign accept  = !in_scan && bus.start;
  // Restart the settle window on each new op and each sample.
  assign cnt_clr = accept || (in_scan && term);

  settle_cnt #(
    .SETTLE (SETTLE)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (in_scan),
    .term_o (term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      word_q  <= RESET_WORD;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        SCAN: begin
          if (term) begin
            word_q[sel_q] <= bus.mux_f;
            if (!mode_q &&
                sel_q != SEL_W'(NUM_CH - 1)) begin
              sel_q <= sel_q + 1'b1;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
            end
          end
        end
        default: begin
          if (bus.start) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
            mode_q  <= bus.mode;
            sel_q   <= bus.mode ? bus.chan : '0;
          end else begin
            state_q <= IDLE;
            sel_q   <= '0;
          end
        end
      endcase
    end
  end

  assign bus.sel   = sel_q;
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.word  = word_q;

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that drives the 2-bit select of the 4:1 gate-level multiplexer directly downstream and captures that mux's output F into a 4-bit word.
- Two modes: sweep all four channels in order 0..3, or sample one chosen channel.
- Optional per-channel settle delay so F is sampled only after the gate chain has settled.
- Sits between control logic (issues start) and the datapath (consumes word/valid).

Parameters:
- SETTLE, 0, idle cycles held on each sel value before sampling mux_f (0..15).
- RESET_WORD, 4'b0000, value loaded into word on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request pulse; accepted only in IDLE or DONE.
- mode  input  1  0 = sweep channels 0..3; 1 = single channel.
- chan  input  2  channel for single mode, latched with start.
- mux_f  input  1  output F of the downstream 4:1 mux.
- sel  output  2  select driven into the mux.
- busy  output  1  high while in SCAN.
- word  output  4  captured bits; word[i] = mux_f sampled with sel = i.
- valid  output  1  one-cycle pulse when word is updated and complete.

Behaviour:
- Reset (rst high at an edge): state = IDLE, sel = 00, busy = 0, valid = 0, word = RESET_WORD, settle counter = 0. rst has priority over start. A reset during SCAN aborts the operation with no valid pulse.
- States:
  - IDLE: sel = 00, busy = 0, valid = 0.
  - SCAN: busy = 1.
  - DONE: valid = 1 for exactly one cycle; busy = 0.
- IDLE/DONE with start = 1 at edge k:
  - Enter SCAN.
  - Latch mode and chan.
  - Set sel to 00 (sweep) or to chan (single).
  - Clear the settle counter.
- IDLE/DONE with start = 0: go to (or stay in) IDLE; sel returns to 00.
- SCAN, per channel:
  - Hold sel for SETTLE+1 cycles. The settle counter increments each cycle.
  - On the edge where counter == SETTLE: word[sel] <= mux_f and the counter clears.
  - Sweep with sel < 3: sel <= sel + 1, stay in SCAN.
  - Sweep with sel == 3, or single mode: go to DONE.
- Latency from start at edge k:
  - Sweep: valid is high in cycle k + 4*(SETTLE+1) + 1.
  - Single: valid is high in cycle k + SETTLE + 2.
- Single mode updates only word[chan]; the other three bits hold their previous values.
- In sweep mode all four bits are overwritten. Bits are visible on word as soon as each is sampled; consumers use word only when valid = 1.
- start while busy = 1 is ignored; it is not queued.
- start in the DONE cycle is accepted, giving back-to-back operation. valid still pulses for the finished operation.
- mode and chan are sampled only with an accepted start. Changes during SCAN have no effect.
- sel increments without wrap past 3; the sweep ends at 3.
- mux_f is sampled only at the sample edges. Glitches on it during settle cycles have no effect.

Decomposition:
- Shared package holds:
  - State encoding: IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2.
  - NUM_CH = 4.
  - SEL_W = 2.
- One sub-module: settle_cnt.
  - 4-bit counter with clear and enable.
  - Output terminal = (count == SETTLE).
  - Synchronous active-high reset on the same clk/rst.
- FSM, sel register and word register live in mux_scan_ctrl.

Test Plan:
- Reset check: drive rst high for 2 cycles with start = 1 held -> sel = 00, busy = 0, valid = 0, word = 0000. No scan starts.
- Sweep with SETTLE = 0 and mux inputs A,B,C,D = 1,0,1,1 through the real gate mux:
  - start at edge k -> sel = 0,1,2,3 in cycles k+1..k+4.
  - busy high in cycles k+1..k+4.
  - valid high in cycle k+5 only, with word = 4'b1101.
- Single mode, mode = 1, chan = 2, with C = 0 and word previously 1111 -> sel = 10 for 1 cycle, valid in cycle k+2, word = 1011.
- SETTLE = 3, sweep -> each sel value held 4 cycles, valid in cycle k+17. Toggling mux_f during the first 3 cycles of each channel does not change word.
- start pulsed during SCAN, then again in the DONE cycle -> first extra start ignored. Second start accepted: sel = 00 and busy = 1 in the cycle after DONE.
- rst asserted in cycle k+2 of a sweep -> next cycle shows the reset values. No valid pulse follows; word = RESET_WORD.
